// File: rtl/press_classifier.sv
// press_classifier: turns single-cycle debounced press events into
// single-click and double-click pulses. A first press opens a window of
// WINDOW cycles. A second press inside that window is a double click.
// If the window runs out with no second press, the result is a single click.
// Every classified event also advances an 8-bit wrapping counter.
module press_classifier #(
  parameter int WINDOW = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_p,
  output logic       single_o,
  output logic       double_o,
  output logic       busy,
  output logic [7:0] click_cnt
);

  // The timer must be able to hold WINDOW itself. It is at least one bit wide.
  localparam int TW = (WINDOW < 2) ? 1 : $clog2(WINDOW + 1);
  localparam logic [TW-1:0] WIN_T = TW'(WINDOW);
  localparam logic [TW-1:0] ONE_T = TW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic            single_q;
  logic            double_q;
  logic [7:0]      cnt_q;

  // FSM, window timer, registered click pulses and event counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      // The click pulses last only one cycle unless they are set again below.
      single_q <= 1'b0;
      double_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Presses are accepted even while a click pulse is showing.
          if (pulse_p) begin
            state_q <= WAIT;
            timer_q <= ONE_T;
          end
        end
        WAIT: begin
          if (pulse_p) begin
            // A second press wins, even on the last window cycle.
            double_q <= 1'b1;
            state_q  <= IDLE;
            timer_q  <= '0;
            cnt_q    <= cnt_q + 8'd1;
          end else if (timer_q == WIN_T) begin
            single_q <= 1'b1;
            state_q  <= IDLE;
            timer_q  <= '0;
            cnt_q    <= cnt_q + 8'd1;
          end else begin
            timer_q <= timer_q + ONE_T;
          end
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  // busy comes straight from the state register.
  always_comb begin
    busy = (state_q == WAIT);
  end

  assign single_o  = single_q;
  assign double_o  = double_q;
  assign click_cnt = cnt_q;

endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: directed bench for press_classifier with WINDOW=4.
// When the bench drives a press, it pushes the expected click event
// (kind, cycle, counter value) into a queue. When the DUT raises a pulse,
// the bench pops that entry and compares it.
module tb_press_classifier;

  localparam int WINDOW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_p = 1'b0;
  logic       single_o;
  logic       double_o;
  logic       busy;
  logic [7:0] click_cnt;

  press_classifier #(.WINDOW(WINDOW)) dut (
    .clk       (clk),
    .rst       (rst),
    .pulse_p   (pulse_p),
    .single_o  (single_o),
    .double_o  (double_o),
    .busy      (busy),
    .click_cnt (click_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_double;
    logic [31:0] cyc;
    logic [7:0]  cnt;
  } ev_t;

  ev_t         sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] cyc = 0;
  logic [7:0]  cnt_exp = 8'd0;
  logic [31:0] t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record an expected click event at an absolute cycle number.
  task automatic expect_ev(input logic is_dbl, input logic [31:0] at);
    ev_t e;
    cnt_exp = cnt_exp + 8'd1;
    e.is_double = is_dbl;
    e.cyc = at;
    e.cnt = cnt_exp;
    sb.push_back(e);
  endtask

  // Drive inputs for one cycle, then sample #1 after the edge and score the outputs.
  task automatic step(input logic p, input logic r);
    ev_t e;
    pulse_p = p;
    rst = r;
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    check("mutex", {31'd0, single_o & double_o}, 32'd0);
    if (single_o === 1'b1 || double_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {31'd0, double_o}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("kind", {31'd0, double_o}, {31'd0, e.is_double});
        check("cycle", cyc, e.cyc);
        check("cnt", {24'd0, click_cnt}, {24'd0, e.cnt});
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check("missing_event", cyc, 32'hFFFF_FFFF);
    end
    $display("cyc=%0d pulse=%b rst=%b -> single=%b double=%b busy=%b cnt=%0d",
             cyc, p, r, single_o, double_o, busy, click_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    cnt_exp = 8'd0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_single"}, {31'd0, single_o}, 32'd0);
    check({tag, "_double"}, {31'd0, double_o}, 32'd0);
    check({tag, "_busy"},   {31'd0, busy},     32'd0);
    check({tag, "_cnt"},    {24'd0, click_cnt}, 32'd0);
  endtask

  initial begin
    // Reset held for 3 cycles while pulse_p toggles. Every output must stay at 0.
    step(1'b1, 1'b1); check_quiet("rst1");
    step(1'b0, 1'b1); check_quiet("rst2");
    step(1'b1, 1'b1); check_quiet("rst3");

    // Single press in the first cycle after reset deasserts.
    t0 = cyc;
    expect_ev(1'b0, t0 + 5);
    step(1'b1, 1'b0);
    check("single_busy_1", {31'd0, busy}, 32'd1);
    for (int k = 2; k <= 4; k++) begin
      step(1'b0, 1'b0);
      check("single_busy_k", {31'd0, busy}, 32'd1);
    end
    step(1'b0, 1'b0);
    check("single_busy_end", {31'd0, busy}, 32'd0);
    check("single_cnt", {24'd0, click_cnt}, 32'd1);
    idle(3);
    check("single_drained", sb.size(), 32'd0);

    // Double click: presses at t0 and t0+2.
    do_reset();
    t0 = cyc;
    expect_ev(1'b1, t0 + 3);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("double_busy", {31'd0, busy}, 32'd0);
    check("double_cnt", {24'd0, click_cnt}, 32'd1);
    idle(6);

    // Boundary: a second press exactly at timer=WINDOW is a double click.
    do_reset();
    t0 = cyc;
    expect_ev(1'b1, t0 + 5);
    step(1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b0);
    idle(6);
    check("bnd_dbl_drained", sb.size(), 32'd0);

    // One cycle too late: single at t0+5. The press during that pulse starts a new window.
    do_reset();
    t0 = cyc;
    expect_ev(1'b0, t0 + 5);
    expect_ev(1'b0, t0 + 10);
    step(1'b1, 1'b0);
    idle(4);
    step(1'b1, 1'b0);
    check("late_busy", {31'd0, busy}, 32'd1);
    idle(4);
    check("late_cnt", {24'd0, click_cnt}, 32'd2);
    idle(2);

    // A third press after a double click opens a fresh window.
    do_reset();
    t0 = cyc;
    expect_ev(1'b1, t0 + 2);
    expect_ev(1'b0, t0 + 7);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle(6);

    // Counter wrap across 256 isolated single presses.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      expect_ev(1'b0, cyc + 5);
      step(1'b1, 1'b0);
      idle(5);
      if (i == 254) check("wrap_255", {24'd0, click_cnt}, 32'd255);
      if (i == 255) check("wrap_0", {24'd0, click_cnt}, 32'd0);
    end

    // Reset in WAIT abandons the pending press. The next press is classified normally.
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    cnt_exp = 8'd0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_cnt", {24'd0, click_cnt}, 32'd0);
    t0 = cyc;
    expect_ev(1'b0, t0 + 5);
    step(1'b1, 1'b0);
    idle(6);

    check("final_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
